ahb_bridge_arbiter: RTL and testbench
=====================================

# ahb_bridge_arbiter

Round-robin arbiter that shares the single AHB slave port of the AHB-to-APB bridge among up to four AHB masters. It tracks bus ownership and muxes the owner's address-phase signals (Haddr, Htrans, Hwrite) to the bridge. It muxes Hwdata using a separately tracked data-phase owner, so pipelined handovers are handled correctly. A per-owner transfer counter bounds tenure so no master can starve the others.

## Interface

Parameters:
- NUM_MASTERS, 3: number of requesters, 2..4; master index is always 2 bits.
- MAX_XFERS, 16: accepted transfers per tenure before forced rotation (1..255).

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Hbusreq  in  NUM_MASTERS  per-master bus request.
- Haddr_m  in  32*NUM_MASTERS  packed master addresses; master i at [32i+31:32i].
- Hwdata_m  in  32*NUM_MASTERS  packed master write data.
- Htrans_m  in  2*NUM_MASTERS  packed master Htrans.
- Hwrite_m  in  NUM_MASTERS  per-master Hwrite.
- Hreadyout  in  1  ready from the bridge.
- Haddr  out  32  to bridge.
- Hwdata  out  32  to bridge.
- Htrans  out  2  to bridge.
- Hwrite  out  1  to bridge.
- Hreadyin  out  1  to bridge; equals Hreadyout combinationally.
- Hgrant  out  NUM_MASTERS  one-hot grant, registered.
- Hmaster  out  2  address-phase owner index, registered.

## Operation

- FSM states:
  - IDLE: no owner. Hgrant=0. Htrans forced to 2'b00; Haddr, Hwdata and Hwrite driven 0.
  - OWNED: one grant bit set; address-phase outputs are the owner's signals.
- IDLE -> OWNED: on any clock with Hbusreq≠0. Grant the first requester found searching from (last_owner+1) mod NUM_MASTERS upward; last_owner resets to NUM_MASTERS-1, so master 0 wins first.
- Rearbitration point in OWNED: Hreadyout=1 AND any of:
  - owner Htrans = IDLE (00);
  - owner Hbusreq = 0;
  - xfer_cnt = MAX_XFERS with another master requesting.
- At a rearbitration point:
  - Another master requesting: grant it round-robin, excluding the current owner.
  - Otherwise, owner still requesting: keep owner and clear xfer_cnt.
  - Otherwise: return to IDLE.
- Accepted transfer: Hreadyout=1 and output Htrans is NONSEQ (10) or SEQ (11). xfer_cnt increments on each one and saturates at MAX_XFERS; it clears on every grant change.
- Data-phase owner (data_master, 2 bits, plus a valid bit):
  - Loaded with Hmaster, and valid set to (Htrans[1]==1), on every clock with Hreadyout=1.
  - Held while Hreadyout=0.
  - Hwdata = Hwdata_m[data_master]; 0 when valid=0.
- Wait states: while Hreadyout=0, Hgrant, Hmaster, xfer_cnt and data_master are all frozen.
- Reset (rst=0, any time, asynchronous):
  - Hgrant=0, Hmaster=0, data_master=0, valid=0, xfer_cnt=0, state IDLE, last_owner=NUM_MASTERS-1.
  - Outputs: Htrans=00, Haddr=0, Hwdata=0, Hwrite=0.

## Timing

- Grant latency: Hbusreq rising in cycle N gives Hgrant/Hmaster in cycle N+1. The owner's first NONSEQ appears on Htrans in N+1 if the master drives it combinationally from Hgrant, else N+2.
- Handover: decided at edge E (rearbitration point with Hreadyout=1).
  - New Hmaster is visible after E.
  - The old owner's last data phase completes with Hwdata still muxed from the old owner, because data_master lags Hmaster by one accepted beat.
- Same-cycle events:
  - Hbusreq deassert and new request in the same cycle: handled as one rearbitration.
  - Owner drops Hbusreq while Hreadyout=0: the grant holds until Hreadyout=1.
- Output paths: Htrans, Haddr, Hwrite and Hwdata are combinational muxes of registered selects. Hreadyin is a pure wire.

## Test plan

- Reset: assert rst=0 mid-transfer with Hgrant=010 -> Hgrant=000, Htrans=00 and Hmaster=0 immediately; first request after release, Hbusreq=111 -> master 0 granted.
- Single master: Hbusreq=001, master 0 issues NONSEQ Haddr=0x1000 Hwrite=1, Hwdata_m[0]=0xA5A5A5A5 -> Haddr=0x1000 in the address phase; Hwdata=0xA5A5A5A5 in the next Hreadyout=1 cycle.
- Round robin: Hbusreq=111, each owner issues one NONSEQ then IDLE -> Hmaster sequence 0,1,2,0.
- Tenure limit: MAX_XFERS=4, master 1 issues continuous SEQ, Hbusreq=011 -> after the 4th accepted beat Hgrant switches to 01 (master 0); master 1 is never granted more than 4 beats consecutively.
- Wait states: Hreadyout held 0 for 3 cycles during master 2 data phase with master 0 requesting -> Hgrant, Hmaster and Hwdata source stay on master 2 until Hreadyout=1.
- Handover data mux: master 0 last write Hwdata_m[0]=0x11111111, handover to master 1 (Hwdata_m[1]=0x22222222) -> Hwdata=0x11111111 in the handover data phase; 0x22222222 only for master 1's beats.

Source files
------------

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter sharing the bridge's AHB slave port among up to four masters; grant lands one cycle after request.
// Bridge backpressure (Hreadyout=0) freezes grant, owner, tenure count and data-phase owner; muxes stay combinational.
module ahb_bridge_arbiter #(
   parameter int NUM_MASTERS = 3,
   parameter int MAX_XFERS   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_MASTERS-1:0]    Hbusreq,
   input  logic [32*NUM_MASTERS-1:0] Haddr_m,
   input  logic [32*NUM_MASTERS-1:0] Hwdata_m,
   input  logic [2*NUM_MASTERS-1:0]  Htrans_m,
   input  logic [NUM_MASTERS-1:0]    Hwrite_m,
   input  logic                      Hreadyout,
   output logic [31:0]               Haddr,
   output logic [31:0]               Hwdata,
   output logic [1:0]                Htrans,
   output logic                      Hwrite,
   output logic                      Hreadyin,
   output logic [NUM_MASTERS-1:0]    Hgrant,
   output logic [1:0]                Hmaster
);

   localparam logic [7:0] MAX_CNT = 8'(MAX_XFERS);
   localparam logic [2:0] NM3     = 3'(NUM_MASTERS);

   typedef enum logic {S_IDLE, S_OWNED} state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  trans;
      logic        write;
      logic        req;
   } mst_t;

   state_t                 state;
   mst_t                   mst [4];
   logic [1:0]             last_owner;
   logic [7:0]             xfer_cnt;
   logic [7:0]             cnt_inc;
   logic [1:0]             data_master;
   logic                   data_vld;
   logic                   owned;
   logic [1:0]             owner_trans;
   logic                   owner_req;
   logic                   accepted;
   logic                   rearb;
   logic [2:0]             rr_sum;
   logic [1:0]             rr_cand;
   logic [1:0]             pick_idx;
   logic                   pick_vld;
   logic [NUM_MASTERS-1:0] pick_onehot;

   // Unpack every master into a fixed 4-entry table so 2-bit indices always fit.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         mst[i] = '0;
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
         mst[i].addr  = Haddr_m[32*i +: 32];
         mst[i].wdata = Hwdata_m[32*i +: 32];
         mst[i].trans = Htrans_m[2*i +: 2];
         mst[i].write = Hwrite_m[i];
         mst[i].req   = Hbusreq[i];
      end
   end

   assign owned       = (state == S_OWNED);
   assign owner_trans = mst[Hmaster].trans;
   assign owner_req   = mst[Hmaster].req;

   assign Htrans   = owned ? owner_trans : 2'b00;
   assign Haddr    = owned ? mst[Hmaster].addr : 32'h0;
   assign Hwrite   = owned ? mst[Hmaster].write : 1'b0;
   assign Hwdata   = data_vld ? mst[data_master].wdata : 32'h0;
   assign Hreadyin = Hreadyout;

   // Search upward from last_owner+1; while owned the current owner is skipped,
   // so pick_vld then means "some other master is requesting".
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      rr_sum   = '0;
      rr_cand  = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         rr_sum = {1'b0, last_owner} + 3'(k);
         if (rr_sum >= NM3) begin
            rr_sum = rr_sum - NM3;
         end
         rr_cand = rr_sum[1:0];
         if (!pick_vld && mst[rr_cand].req && !(owned && rr_cand == Hmaster)) begin
            pick_vld = 1'b1;
            pick_idx = rr_cand;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
         pick_onehot[i] = (pick_idx == 2'(i));
      end
   end

   // The beat on the bus at the limit edge counts, so a tenure never exceeds MAX_XFERS beats.
   assign accepted = Hreadyout && Htrans[1];
   assign cnt_inc  = (accepted && xfer_cnt != MAX_CNT) ? xfer_cnt + 8'd1 : xfer_cnt;
   assign rearb    = owned && Hreadyout &&
                     (owner_trans == 2'b00 || !owner_req || (cnt_inc == MAX_CNT && pick_vld));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         Hgrant      <= '0;
         Hmaster     <= '0;
         last_owner  <= 2'(NUM_MASTERS - 1);
         xfer_cnt    <= '0;
         data_master <= '0;
         data_vld    <= 1'b0;
      end else if (Hreadyout) begin
         data_master <= Hmaster;
         data_vld    <= Htrans[1];
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  state      <= S_OWNED;
                  Hgrant     <= pick_onehot;
                  Hmaster    <= pick_idx;
                  last_owner <= pick_idx;
                  xfer_cnt   <= '0;
               end
            end
            S_OWNED: begin
               if (rearb) begin
                  xfer_cnt <= '0;
                  if (pick_vld) begin
                     Hgrant     <= pick_onehot;
                     Hmaster    <= pick_idx;
                     last_owner <= pick_idx;
                  end else if (!owner_req) begin
                     state  <= S_IDLE;
                     Hgrant <= '0;
                  end
               end else begin
                  xfer_cnt <= cnt_inc;
               end
            end
            default: begin
               state  <= S_IDLE;
               Hgrant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Bench for ahb_bridge_arbiter: directed scenarios plus a randomized run against a rule-level model.
module tb_ahb_bridge_arbiter;

   localparam int NM   = 3;
   localparam int MAXX = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              m_req   [NM];
   logic [31:0]       m_addr  [NM];
   logic [31:0]       m_wdata [NM];
   logic [1:0]        m_trans [NM];
   logic              m_write [NM];
   logic              Hreadyout;
   logic [NM-1:0]     Hbusreq;
   logic [32*NM-1:0]  Haddr_m;
   logic [32*NM-1:0]  Hwdata_m;
   logic [2*NM-1:0]   Htrans_m;
   logic [NM-1:0]     Hwrite_m;
   logic [31:0]       Haddr;
   logic [31:0]       Hwdata;
   logic [1:0]        Htrans;
   logic              Hwrite;
   logic              Hreadyin;
   logic [NM-1:0]     Hgrant;
   logic [1:0]        Hmaster;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int mo;
   int ml;
   int mc;
   int mdm;
   bit mdv;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NM; i++) begin
         Hbusreq[i]            = m_req[i];
         Haddr_m[32*i +: 32]   = m_addr[i];
         Hwdata_m[32*i +: 32]  = m_wdata[i];
         Htrans_m[2*i +: 2]    = m_trans[i];
         Hwrite_m[i]           = m_write[i];
      end
   end

   ahb_bridge_arbiter #(.NUM_MASTERS(NM), .MAX_XFERS(MAXX)) dut (
      .clk(clk), .rst(rst), .Hbusreq(Hbusreq), .Haddr_m(Haddr_m), .Hwdata_m(Hwdata_m),
      .Htrans_m(Htrans_m), .Hwrite_m(Hwrite_m), .Hreadyout(Hreadyout), .Haddr(Haddr),
      .Hwdata(Hwdata), .Htrans(Htrans), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
      .Hgrant(Hgrant), .Hmaster(Hmaster)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < NM; i++) begin
         m_req[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0; m_trans[i] = 2'b00; m_write[i] = 1'b0;
      end
      Hreadyout = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < NM; i++) begin
         m_req[i] = 1'b1; m_addr[i] = 32'hDEAD_0000 + i; m_wdata[i] = 32'hBEEF_0000 + i;
         m_trans[i] = 2'b10; m_write[i] = 1'b1;
      end
      Hreadyout = 1'b1;
      tick(); tick();
      @(negedge clk);
      checks++; if (Hgrant !== 3'b000) begin failures++; $display("FAIL reset_hgrant got=%b exp=000", Hgrant); end
      checks++; if (Hmaster !== 2'd0) begin failures++; $display("FAIL reset_hmaster got=%0d exp=0", Hmaster); end
      checks++; if (Htrans !== 2'b00 || Haddr !== 32'h0 || Hwrite !== 1'b0 || Hwdata !== 32'h0) begin
         failures++; $display("FAIL reset_outputs got trans=%b addr=%h wr=%b wdata=%h exp all zero", Htrans, Haddr, Hwrite, Hwdata);
      end
      tick();
      rst = 1'b1;
      for (int i = 0; i < NM; i++) m_req[i] = (i == 1);
      tick();
      @(negedge clk);
      checks++; if (Hgrant !== 3'b010) begin failures++; $display("FAIL reset_pregrant got=%b exp=010", Hgrant); end
      #2 rst = 1'b0;
      #1;
      checks++; if (Hgrant !== 3'b000 || Htrans !== 2'b00 || Hmaster !== 2'd0) begin
         failures++; $display("FAIL reset_async got grant=%b trans=%b master=%0d exp 000/00/0", Hgrant, Htrans, Hmaster);
      end
      tick();
      rst = 1'b1;
      for (int i = 0; i < NM; i++) m_req[i] = 1'b1;
      tick();
      @(negedge clk);
      checks++; if (Hgrant !== 3'b001 || Hmaster !== 2'd0) begin
         failures++; $display("FAIL reset_first_grant got grant=%b master=%0d exp 001/0", Hgrant, Hmaster);
      end
   endtask

   task automatic test_single();
      do_reset();
      m_req[0] = 1'b1; m_trans[0] = 2'b10; m_addr[0] = 32'h0000_1000; m_write[0] = 1'b1;
      m_wdata[0] = 32'hA5A5_A5A5;
      tick();
      @(negedge clk);
      checks++; if (Hgrant !== 3'b001 || Hmaster !== 2'd0) begin
         failures++; $display("FAIL single_grant got grant=%b master=%0d exp 001/0", Hgrant, Hmaster);
      end
      checks++; if (Haddr !== 32'h1000 || Htrans !== 2'b10 || Hwrite !== 1'b1) begin
         failures++; $display("FAIL single_addr got addr=%h trans=%b wr=%b exp 1000/10/1", Haddr, Htrans, Hwrite);
      end
      checks++; if (Hwdata !== 32'h0) begin failures++; $display("FAIL single_wdata_early got=%h exp=0", Hwdata); end
      tick();
      m_trans[0] = 2'b00;
      @(negedge clk);
      checks++; if (Hwdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL single_wdata got=%h exp=a5a5a5a5", Hwdata); end
      tick();
      @(negedge clk);
      checks++; if (Hwdata !== 32'h0) begin failures++; $display("FAIL single_wdata_after got=%h exp=0", Hwdata); end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < NM; i++) begin
         m_req[i] = 1'b1; m_trans[i] = 2'b10; m_addr[i] = 32'h100 * (i + 1);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (Hmaster !== 2'(i % NM)) begin
            failures++; $display("FAIL rr_master step=%0d got=%0d exp=%0d", i, Hmaster, i % NM);
         end
         checks++; if (Hgrant !== 3'(1 << (i % NM))) begin
            failures++; $display("FAIL rr_grant step=%0d got=%b exp=%b", i, Hgrant, 3'(1 << (i % NM)));
         end
         tick();
         m_trans[i % NM] = 2'b00;
         tick();
         m_trans[i % NM] = 2'b10;
      end
   endtask

   task automatic test_tenure();
      int beats = 0;
      bit switched = 1'b0;
      do_reset();
      m_req[1] = 1'b1; m_trans[1] = 2'b10;
      tick();
      m_req[0] = 1'b1; m_trans[0] = 2'b10;
      for (int cyc = 0; cyc < 12 && !switched; cyc++) begin
         @(negedge clk);
         if (Hgrant == 3'b001) begin
            switched = 1'b1;
         end else begin
            if (Hmaster == 2'd1 && Htrans[1] && Hreadyout) beats++;
            tick();
            m_trans[1] = 2'b11;
         end
      end
      checks++; if (!switched) begin failures++; $display("FAIL tenure_timeout got grant=%b exp=001 within 12 cycles", Hgrant); end
      checks++; if (beats !== MAXX) begin failures++; $display("FAIL tenure_beats got=%0d exp=%0d", beats, MAXX); end
      checks++; if (Hmaster !== 2'd0) begin failures++; $display("FAIL tenure_master got=%0d exp=0", Hmaster); end
   endtask

   task automatic test_wait_states();
      do_reset();
      m_req[2] = 1'b1; m_trans[2] = 2'b10; m_wdata[2] = 32'hC0DE_0002; m_write[2] = 1'b1;
      tick();
      tick();
      m_req[2] = 1'b0; m_trans[2] = 2'b00; m_req[0] = 1'b1; Hreadyout = 1'b0;
      for (int w = 0; w < 4; w++) begin
         if (w == 3) Hreadyout = 1'b1;
         @(negedge clk);
         checks++; if (Hgrant !== 3'b100 || Hmaster !== 2'd2 || Hwdata !== 32'hC0DE_0002) begin
            failures++; $display("FAIL wait_hold cyc=%0d got grant=%b master=%0d wdata=%h exp 100/2/c0de0002", w, Hgrant, Hmaster, Hwdata);
         end
         tick();
      end
      @(negedge clk);
      checks++; if (Hgrant !== 3'b001 || Hmaster !== 2'd0 || Hwdata !== 32'h0) begin
         failures++; $display("FAIL wait_release got grant=%b master=%0d wdata=%h exp 001/0/0", Hgrant, Hmaster, Hwdata);
      end
   endtask

   task automatic test_handover();
      do_reset();
      m_req[0] = 1'b1; m_trans[0] = 2'b10; m_write[0] = 1'b1; m_wdata[0] = 32'h1111_1111; m_addr[0] = 32'h10;
      m_req[1] = 1'b1; m_trans[1] = 2'b10; m_write[1] = 1'b1; m_wdata[1] = 32'h2222_2222; m_addr[1] = 32'h20;
      tick();
      m_req[0] = 1'b0;
      tick();
      @(negedge clk);
      checks++; if (Hmaster !== 2'd1 || Haddr !== 32'h20) begin
         failures++; $display("FAIL handover_owner got master=%0d addr=%h exp 1/20", Hmaster, Haddr);
      end
      checks++; if (Hwdata !== 32'h1111_1111) begin failures++; $display("FAIL handover_old_data got=%h exp=11111111", Hwdata); end
      tick();
      m_trans[1] = 2'b00;
      @(negedge clk);
      checks++; if (Hwdata !== 32'h2222_2222) begin failures++; $display("FAIL handover_new_data got=%h exp=22222222", Hwdata); end
      tick();
      @(negedge clk);
      checks++; if (Hwdata !== 32'h0) begin failures++; $display("FAIL handover_data_idle got=%h exp=0", Hwdata); end
   endtask

   // Advance the rule-level model by one clock edge using the inputs the DUT just sampled.
   task automatic model_step();
      logic [1:0] t;
      int nc;
      int nxt;
      if (!Hreadyout) return;
      t   = (mo < 0) ? 2'b00 : m_trans[mo];
      mdv = t[1];
      if (mo >= 0) mdm = mo;
      if (mo < 0) begin
         for (int k = 1; k <= NM; k++) begin
            if (mo < 0 && m_req[(ml + k) % NM]) begin
               mo = (ml + k) % NM; ml = mo; mc = 0;
            end
         end
      end else begin
         nc  = (mc + int'(t[1]) > MAXX) ? MAXX : mc + int'(t[1]);
         nxt = -1;
         for (int k = 1; k < NM; k++) begin
            if (nxt < 0 && m_req[(mo + k) % NM]) nxt = (mo + k) % NM;
         end
         if (t == 2'b00 || !m_req[mo] || (nc == MAXX && nxt >= 0)) begin
            mc = 0;
            if (nxt >= 0) begin
               mo = nxt; ml = nxt;
            end else if (!m_req[mo]) begin
               mo = -1;
            end
         end else begin
            mc = nc;
         end
      end
   endtask

   task automatic test_random();
      logic [NM-1:0] eg;
      logic [1:0]    et;
      logic [31:0]   ea;
      logic          ew;
      logic [31:0]   ed;
      int            v;
      do_reset();
      mo = -1; ml = NM - 1; mc = 0; mdm = 0; mdv = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < NM; i++) begin
            if ($urandom_range(0, 3) == 0) m_req[i] = ~m_req[i];
            v = $urandom_range(0, 7);
            m_trans[i] = (v == 0) ? 2'b00 : (v == 1) ? 2'b01 : (v < 5) ? 2'b10 : 2'b11;
            m_addr[i]  = $urandom;
            m_wdata[i] = $urandom;
            m_write[i] = 1'($urandom_range(0, 1));
         end
         Hreadyout = (mo < 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         @(negedge clk);
         eg = '0;
         if (mo >= 0) eg[mo] = 1'b1;
         et = (mo < 0) ? 2'b00 : m_trans[mo];
         ea = (mo < 0) ? 32'h0 : m_addr[mo];
         ew = (mo < 0) ? 1'b0 : m_write[mo];
         ed = mdv ? m_wdata[mdm] : 32'h0;
         checks++; if (Hgrant !== eg) begin failures++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, Hgrant, eg); end
         checks++; if (Htrans !== et || Haddr !== ea || Hwrite !== ew) begin
            failures++; $display("FAIL rand_addr_phase cyc=%0d got %b/%h/%b exp %b/%h/%b", cyc, Htrans, Haddr, Hwrite, et, ea, ew);
         end
         checks++; if (Hwdata !== ed) begin failures++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", cyc, Hwdata, ed); end
         checks++; if (Hreadyin !== Hreadyout) begin failures++; $display("FAIL rand_hreadyin cyc=%0d got=%b exp=%b", cyc, Hreadyin, Hreadyout); end
         if (mo >= 0) begin
            checks++; if (Hmaster !== 2'(mo)) begin failures++; $display("FAIL rand_hmaster cyc=%0d got=%0d exp=%0d", cyc, Hmaster, mo); end
         end
         @(posedge clk);
         model_step();
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got no finish exp finish before 1000000");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_tenure();
      test_wait_states();
      test_handover();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
